// File: rtl/game_ctrl.sv
// Tic-tac-toe move controller: validates requested moves against the external board,
// drives a submit/refresh commit handshake, and scores the board after each commit.
module game_ctrl #(
    parameter logic [1:0]  FIRST_PLAYER = 2'b01,
    parameter int unsigned ACK_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_valid,
    input  logic [1:0]  move_player,
    input  logic [3:0]  move_loc,
    output logic        move_ready,
    input  logic        new_game,
    input  logic [17:0] board_state,
    input  logic        refresh,
    output logic [3:0]  update_loc,
    output logic [1:0]  update_val,
    output logic        submit,
    output logic        board_reset,
    output logic [1:0]  turn,
    output logic [1:0]  status,
    output logic        move_reject,
    output logic [1:0]  reject_code,
    output logic [3:0]  move_count
);

    typedef enum logic [2:0] {
        S_RST,
        S_CLEAR,
        S_IDLE,
        S_CHECK,
        S_SUBMIT,
        S_WAIT_ACK,
        S_EVAL,
        S_OVER
    } state_t;

    localparam logic [1:0] CELL_X      = 2'b01;
    localparam logic [1:0] CELL_O      = 2'b10;
    localparam logic [1:0] ST_PLAYING  = 2'b00;
    localparam logic [1:0] ST_DRAW     = 2'b11;
    localparam logic [1:0] RC_TIMEOUT  = 2'b00;
    localparam logic [1:0] RC_BAD_IDX  = 2'b01;
    localparam logic [1:0] RC_WRONG_PL = 2'b10;
    localparam logic [1:0] RC_OCCUPIED = 2'b11;
    localparam logic [3:0] MAX_MOVES   = 4'd9;
    localparam int unsigned CNT_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    // Cell indices of the eight winning lines: three rows, three columns, two diagonals.
    localparam logic [3:0] LINE_CELL [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        logic [1:0] v;
        v = 2'b00;
        for (int i = 0; i < 9; i++) begin
            if (idx == 4'(i)) v = b[2*i +: 2];
        end
        return v;
    endfunction

    function automatic logic [1:0] line_winner(input logic [17:0] b);
        logic [1:0] w;
        logic [1:0] c0, c1, c2;
        w = 2'b00;
        for (int l = 0; l < 8; l++) begin
            c0 = cell_at(b, LINE_CELL[l][0]);
            c1 = cell_at(b, LINE_CELL[l][1]);
            c2 = cell_at(b, LINE_CELL[l][2]);
            if (c0 != 2'b00 && c0 == c1 && c1 == c2) w = c0;
        end
        return w;
    endfunction

    function automatic logic board_full(input logic [17:0] b);
        logic f;
        f = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (b[2*i +: 2] == 2'b00) f = 1'b0;
        end
        return f;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       turn_q, turn_d;
    logic [1:0]       status_q, status_d;
    logic [3:0]       count_q, count_d;
    logic [3:0]       loc_q, loc_d;
    logic [1:0]       player_q, player_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;

    logic       chk_reject;
    logic [1:0] chk_code;
    logic       ack_expired;
    logic [1:0] winner;
    logic       full;

    always_comb begin
        chk_reject = 1'b1;
        chk_code   = RC_TIMEOUT;
        if (loc_q > 4'd8) begin
            chk_code = RC_BAD_IDX;
        end else if (player_q != turn_q) begin
            chk_code = RC_WRONG_PL;
        end else if (cell_at(board_state, loc_q) != 2'b00) begin
            chk_code = RC_OCCUPIED;
        end else begin
            chk_reject = 1'b0;
        end
    end

    assign ack_expired = (ack_cnt_q == CNT_LAST);
    assign winner      = line_winner(board_state);
    assign full        = board_full(board_state);

    // NOTE: every register, state included, is cleared by the async reset; the reset
    // state S_RST waits one clock so board_reset is only pulsed from a clean CLEAR.
    // NOTE: sequential blocks use non-blocking assignments only, so all flops sample
    // the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RST:      state_d = S_CLEAR;
            S_CLEAR:    state_d = S_IDLE;
            S_IDLE:     if (move_valid) state_d = S_CHECK;
            S_CHECK:    state_d = chk_reject ? S_IDLE : S_SUBMIT;
            S_SUBMIT:   state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (refresh)          state_d = S_EVAL;
                else if (ack_expired) state_d = S_IDLE;
            end
            S_EVAL:     state_d = (winner != 2'b00 || full) ? S_OVER : S_IDLE;
            S_OVER:     state_d = S_OVER;
            default:    state_d = S_RST;
        endcase
        // A restart request overrides whatever the current state would do next.
        if (new_game) state_d = S_CLEAR;
    end

    always_comb begin
        move_ready  = (state_q == S_IDLE);
        board_reset = (state_q == S_CLEAR);
        submit      = (state_q == S_SUBMIT) && !new_game;
        update_loc  = 4'd0;
        update_val  = 2'b00;
        move_reject = 1'b0;
        reject_code = 2'b00;
        if (state_q == S_SUBMIT || state_q == S_WAIT_ACK) begin
            update_loc = loc_q;
            update_val = player_q;
        end
        if (!new_game) begin
            if (state_q == S_CHECK && chk_reject) begin
                move_reject = 1'b1;
                reject_code = chk_code;
            end else if (state_q == S_WAIT_ACK && !refresh && ack_expired) begin
                move_reject = 1'b1;
                reject_code = RC_TIMEOUT;
            end
        end
    end

    // NOTE: each next-state value starts from its current register value, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        turn_d    = turn_q;
        status_d  = status_q;
        count_d   = count_q;
        loc_d     = loc_q;
        player_d  = player_q;
        ack_cnt_d = ack_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (move_valid) begin
                    loc_d    = move_loc;
                    player_d = move_player;
                end
            end
            S_SUBMIT: ack_cnt_d = '0;
            S_WAIT_ACK: begin
                if (refresh) begin
                    count_d = (count_q == MAX_MOVES) ? MAX_MOVES : count_q + 4'd1;
                end else if (!ack_expired) begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            S_EVAL: begin
                if (winner != 2'b00) begin
                    status_d = winner;
                end else if (full) begin
                    status_d = ST_DRAW;
                end else begin
                    turn_d = (turn_q == CELL_X) ? CELL_O : CELL_X;
                end
            end
            default: ;
        endcase
        // Game bookkeeping is already clear while CLEAR is showing board_reset.
        if (state_d == S_CLEAR) begin
            turn_d   = FIRST_PLAYER;
            status_d = ST_PLAYING;
            count_d  = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_q    <= FIRST_PLAYER;
            status_q  <= ST_PLAYING;
            count_q   <= 4'd0;
            loc_q     <= 4'd0;
            player_q  <= 2'b00;
            ack_cnt_q <= '0;
        end else begin
            turn_q    <= turn_d;
            status_q  <= status_d;
            count_q   <= count_d;
            loc_q     <= loc_d;
            player_q  <= player_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    assign turn       = turn_q;
    assign status     = status_q;
    assign move_count = count_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed game scenarios plus randomized move
// attempts, scored against a rule-level model of the game kept in this file.
module tb_game_ctrl;

    localparam logic [1:0] FIRST = 2'b01;
    localparam int         TO    = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        move_valid;
    logic [1:0]  move_player;
    logic [3:0]  move_loc;
    logic        move_ready;
    logic        new_game;
    logic [17:0] board_state;
    logic        refresh;
    logic [3:0]  update_loc;
    logic [1:0]  update_val;
    logic        submit;
    logic        board_reset;
    logic [1:0]  turn;
    logic [1:0]  status;
    logic        move_reject;
    logic [1:0]  reject_code;
    logic [3:0]  move_count;

    int n_checks = 0;
    int n_fail   = 0;

    game_ctrl #(.FIRST_PLAYER(FIRST), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .move_valid(move_valid), .move_player(move_player), .move_loc(move_loc),
        .move_ready(move_ready), .new_game(new_game), .board_state(board_state),
        .refresh(refresh), .update_loc(update_loc), .update_val(update_val),
        .submit(submit), .board_reset(board_reset), .turn(turn), .status(status),
        .move_reject(move_reject), .reject_code(reject_code), .move_count(move_count)
    );

    always #5 clk = ~clk;

    // Board peripheral: clears on board_reset, commits the held cell value on refresh.
    logic [1:0] brd [9];
    always @(posedge clk) begin
        if (!rst_n || board_reset) begin
            for (int i = 0; i < 9; i++) brd[i] <= 2'b00;
        end else if (refresh && update_val != 2'b00 && update_loc < 4'd9) begin
            brd[update_loc] <= update_val;
        end
    end
    always_comb begin
        board_state = '0;
        for (int i = 0; i < 9; i++) board_state[2*i +: 2] = brd[i];
    end

    // Rule-level game model.
    int m_cell [9];
    int m_turn, m_status, m_count;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic void m_reset();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_turn = int'(FIRST); m_status = 0; m_count = 0;
    endfunction

    // -1 means the move is legal; otherwise the expected reject code.
    function automatic int m_code(input int p, input int loc);
        if (loc > 8)          return 1;
        if (p != m_turn)      return 2;
        if (m_cell[loc] != 0) return 3;
        return -1;
    endfunction

    function automatic void m_commit(input int p, input int loc);
        int filled;
        m_cell[loc] = p;
        if (m_count < 9) m_count++;
        for (int l = 0; l < 8; l++) begin
            if (m_cell[lines[l][0]] != 0 && m_cell[lines[l][0]] == m_cell[lines[l][1]]
                && m_cell[lines[l][1]] == m_cell[lines[l][2]]) m_status = m_cell[lines[l][0]];
        end
        filled = 0;
        for (int i = 0; i < 9; i++) if (m_cell[i] != 0) filled++;
        if (m_status == 0) begin
            if (filled == 9) m_status = 3;
            else m_turn = (m_turn == 1) ? 2 : 1;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (move_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (move_ready !== 1'b1) check("ready_wait", move_ready, 1);
    endtask

    task automatic check_game(input string tag);
        check({tag, "_turn"},   turn,       m_turn);
        check({tag, "_status"}, status,     m_status);
        check({tag, "_count"},  move_count, m_count);
    endtask

    task automatic do_move(input logic [1:0] p, input logic [3:0] loc, input int delay);
        int ec;
        ec = m_code(int'(p), int'(loc));
        wait_ready();
        move_valid = 1'b1; move_player = p; move_loc = loc; refresh = 1'($urandom);
        @(posedge clk); #1;
        move_valid = 1'b0; refresh = 1'b0;
        move_player = 2'($urandom); move_loc = 4'($urandom);
        @(negedge clk);
        check("check_ready", move_ready, 0);
        check("check_updloc", update_loc, 0);
        if (ec >= 0) begin
            check("reject", move_reject, 1);
            check("reject_code", reject_code, ec);
            check("reject_nosubmit", submit, 0);
            @(posedge clk); @(negedge clk);
            check("reject_idle", move_ready, 1);
            check_game("reject");
            return;
        end
        check("accept_noreject", move_reject, 0);
        @(posedge clk); @(negedge clk);
        check("submit", submit, 1);
        check("submit_loc", update_loc, loc);
        check("submit_val", update_val, p);
        for (int k = 0; k < TO; k++) begin
            @(posedge clk); #1;
            refresh = (k == delay);
            @(negedge clk);
            check("wait_submit", submit, 0);
            check("hold_loc", update_loc, loc);
            check("hold_val", update_val, p);
            check("wait_reject", move_reject, (delay >= TO && k == TO - 1) ? 1 : 0);
            if (move_reject) check("timeout_code", reject_code, 0);
            if (k == delay || k == TO - 1) break;
        end
        @(posedge clk); #1;
        refresh = 1'b0;
        @(negedge clk);
        if (delay >= TO) begin
            check("timeout_idle", move_ready, 1);
            check_game("timeout");
            return;
        end
        m_commit(int'(p), int'(loc));
        check("eval_ready", move_ready, 0);
        check("eval_count", move_count, m_count);
        @(posedge clk); @(negedge clk);
        check_game("commit");
        check("commit_ready", move_ready, (m_status == 0) ? 1 : 0);
        check("commit_cell", brd[loc], p);
    endtask

    task automatic start_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        m_reset();
        @(negedge clk);
        check("ng_board_reset", board_reset, 1);
        check_game("ng");
        check("ng_ready", move_ready, 0);
        @(posedge clk); @(negedge clk);
        check("ng_idle", move_ready, 1);
        check("ng_pulse_end", board_reset, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  move_ready,  0);
        check({tag, "_submit"}, submit,      0);
        check({tag, "_rej"},    move_reject, 0);
        check({tag, "_code"},   reject_code, 0);
        check({tag, "_uloc"},   update_loc,  0);
        check({tag, "_uval"},   update_val,  0);
        check({tag, "_status"}, status,      0);
        check({tag, "_count"},  move_count,  0);
        check({tag, "_turn"},   turn,        FIRST);
        check({tag, "_brst"},   board_reset, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] p;
        logic [3:0] loc;
        int         dly;

        rst_n = 1'b0; move_valid = 1'b0; move_player = 2'b00; move_loc = 4'd0;
        new_game = 1'b0; refresh = 1'b0;
        m_reset();

        // Reset and release.
        #12;
        check_reset_outputs("rst");
        #10 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("first_clear", board_reset, 1);
        check("first_clear_ready", move_ready, 0);
        @(posedge clk); @(negedge clk);
        check("first_idle", move_ready, 1);
        check("first_idle_brst", board_reset, 0);

        // First move and each reject code.
        do_move(2'b01, 4'd4, 0);
        do_move(2'b10, 4'd4, 0);
        do_move(2'b01, 4'd0, 0);
        do_move(2'b10, 4'd9, 0);
        do_move(2'b11, 4'd0, 0);
        do_move(2'b10, 4'd15, 2);
        do_move(2'b10, 4'd0, 3);

        // X wins on the top row.
        start_new_game();
        do_move(2'b01, 4'd0, 0);
        do_move(2'b10, 4'd3, 0);
        do_move(2'b01, 4'd1, 0);
        do_move(2'b10, 4'd4, 0);
        do_move(2'b01, 4'd2, 0);
        check("xwin_status", status, 2'b01);
        move_valid = 1'b1; move_player = 2'b10; move_loc = 4'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("over_ready", move_ready, 0);
            check("over_submit", submit, 0);
            check("over_reject", move_reject, 0);
            check("over_status", status, 2'b01);
        end
        move_valid = 1'b0;

        // Nine-move draw.
        start_new_game();
        do_move(2'b01, 4'd0, 0); do_move(2'b10, 4'd1, 1); do_move(2'b01, 4'd2, 0);
        do_move(2'b10, 4'd4, 0); do_move(2'b01, 4'd3, 2); do_move(2'b10, 4'd5, 0);
        do_move(2'b01, 4'd7, 0); do_move(2'b10, 4'd6, 0); do_move(2'b01, 4'd8, 0);
        check("draw_status", status, 2'b11);
        check("draw_count", move_count, 9);

        // Acknowledge timeout, last-cycle acknowledge, then abort mid-commit.
        start_new_game();
        do_move(2'b01, 4'd4, TO + 5);
        do_move(2'b01, 4'd4, TO - 1);
        wait_ready();
        move_valid = 1'b1; move_player = 2'b10; move_loc = 4'd0;
        @(posedge clk); #1 move_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 new_game = 1'b1;
        @(negedge clk);
        check("abort_noreject", move_reject, 0);
        check("abort_nosubmit", submit, 0);
        @(posedge clk); #1 new_game = 1'b0;
        m_reset();
        @(negedge clk);
        check("abort_brst", board_reset, 1);
        check_game("abort");
        @(posedge clk); @(negedge clk);
        check("abort_idle", move_ready, 1);
        check("abort_cell", brd[0], 0);

        // Randomized play.
        for (int it = 0; it < 60; it++) begin
            if (m_status != 0) start_new_game();
            p   = ($urandom % 5 == 0) ? 2'($urandom) : 2'(m_turn);
            loc = ($urandom % 8 == 0) ? 4'(9 + $urandom % 7) : 4'($urandom % 9);
            dly = ($urandom % 8 == 0) ? TO + int'($urandom % 3) : int'($urandom % 4);
            do_move(p, loc, dly);
        end

        // Asynchronous reset while SUBMIT is showing.
        if (m_status != 0) start_new_game();
        do_move(2'(m_turn), 4'(m_cell[4] == 0 ? 4 : (m_cell[0] == 0 ? 0 : 9)), 0);
        if (m_status != 0) start_new_game();
        loc = 4'd9;
        for (int i = 8; i >= 0; i--) if (m_cell[i] == 0) loc = 4'(i);
        wait_ready();
        move_valid = 1'b1; move_player = 2'(m_turn); move_loc = loc;
        @(posedge clk); #1 move_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pre_rst_submit", submit, (loc < 4'd9) ? 1 : 0);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_reset();
        @(negedge clk);
        check("rst_hold_brst", board_reset, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_clear", board_reset, 1);
        @(posedge clk); @(negedge clk);
        check("rst_idle", move_ready, 1);
        do_move(FIRST, 4'd8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter FIRST_PLAYER, default 2'b01 (X); cell value of the player who moves first after every board clear.
REQ-002 Parameter ACK_TIMEOUT, default 15; maximum cycles spent in WAIT_ACK before the move is abandoned.
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 move_valid  in  1  requester holds a move request.
REQ-007 move_player  in  2  requesting player; 01=X, 10=O, others illegal.
REQ-008 move_loc  in  4  target cell, 0..8 row-major.
REQ-009 move_ready  out  1  controller accepts a move this cycle.
REQ-010 new_game  in  1  single-cycle request to clear and restart.
REQ-011 board_state  in  18  board cell values; cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O.
REQ-012 refresh  in  1  board commit acknowledge.
REQ-013 update_loc  out  4  cell index driven to board.
REQ-014 update_val  out  2  cell value driven to board.
REQ-015 submit  out  1  one-cycle write strobe to board.
REQ-016 board_reset  out  1  one-cycle board clear strobe.
REQ-017 turn  out  2  player expected to move next.
REQ-018 status  out  2  00 playing, 01 X wins, 10 O wins, 11 draw.
REQ-019 move_reject  out  1  one-cycle pulse for a refused move; reject_code  out  2  valid with it: 01 bad index, 10 wrong player, 11 occupied, 00 ack timeout.
REQ-020 move_count  out  4  committed moves this game, 0..9.

Function
REQ-021 States SHALL be CLEAR, IDLE, CHECK, SUBMIT, WAIT_ACK, EVAL, OVER.
REQ-022 CLEAR: board_reset=1 for exactly one cycle; turn<=FIRST_PLAYER, status<=00, move_count<=0; next IDLE.
REQ-023 IDLE: move_ready=1; handshake when move_valid&&move_ready; capture move_player/move_loc; next CHECK.
REQ-024 move_ready SHALL be 0 in every state except IDLE.
REQ-025 CHECK, priority order: move_loc>8 -> code 01; move_player!=turn -> code 10; addressed cell nonzero -> code 11; any reject pulses move_reject one cycle and returns to IDLE with board untouched.
REQ-026 CHECK pass -> SUBMIT: submit=1 one cycle, update_loc/update_val = captured values; both held stable from SUBMIT until exit of WAIT_ACK.
REQ-027 WAIT_ACK: refresh=1 -> EVAL; cycle counter reaching ACK_TIMEOUT without refresh -> move_reject code 00, turn unchanged, next IDLE.
REQ-028 refresh outside WAIT_ACK SHALL be ignored.
REQ-029 EVAL: examine 3 rows, 3 columns, 2 diagonals of board_state; line of three equal nonzero -> status=that value, OVER.
REQ-030 EVAL no win and all 9 cells nonzero -> status=11, OVER; otherwise turn toggles X<->O, IDLE.
REQ-031 move_count SHALL increment by 1 on every EVAL entry and saturate at 9.
REQ-032 OVER: status held, move_ready=0, move_valid ignored, remain until new_game.
REQ-033 new_game SHALL take priority in every state (including WAIT_ACK mid-commit) and force CLEAR next cycle; no reject or submit pulse issued for the aborted move.
REQ-034 Latency: handshake at cycle N -> CHECK N+1 -> submit N+2 -> earliest refresh N+3 -> EVAL N+4 -> move_ready N+5.
REQ-035 update_loc/update_val SHALL be 0 when not in SUBMIT or WAIT_ACK.

Reset
REQ-036 rst_n low SHALL immediately force state CLEAR-pending, move_ready=0, submit=0, move_reject=0, reject_code=00, update_loc=0, update_val=0, status=00, move_count=0, turn=FIRST_PLAYER, board_reset=0.
REQ-037 First clock after rst_n deasserts SHALL enter CLEAR (board_reset pulse), then IDLE.

Verification
REQ-038 Reset release, then X at 4 with refresh 1 cycle after submit -> submit with update_loc=4, update_val=01; turn becomes 10; move_count=1.
REQ-039 O attempts cell 4 after X -> move_reject, reject_code=11, no submit; X attempts next -> reject_code=10; move_loc=9 -> reject_code=01.
REQ-040 X at 0,1,2 interleaved with O at 3,4 -> status=01 after fifth EVAL, move_ready=0, further move_valid ignored.
REQ-041 Nine-move draw sequence X0 O1 X2 O4 X3 O5 X7 O6 X8 -> status=11, move_count=9.
REQ-042 Withhold refresh 15 cycles -> move_reject code 00, turn unchanged; new_game asserted during WAIT_ACK -> board_reset next cycle, status=00, move_count=0, turn=FIRST_PLAYER.
REQ-043 rst_n pulsed low mid-SUBMIT -> submit and all outputs at REQ-036 values asynchronously, CLEAR after release.
